// File: rtl/fm_seq_pkg.sv
// Shared types and defaults for the frame-memory cycle sequencer.
// Slot order repeats IV_WR, PROC, OV_RD, PROC.
package fm_seq_pkg;

    typedef enum logic [1:0] {
        SLOT_IVWR   = 2'd0,
        SLOT_PROC_A = 2'd1,
        SLOT_OVRD   = 2'd2,
        SLOT_PROC_B = 2'd3
    } slot_e;

    localparam int SLOT_LEN_DEF = 64;
    localparam int ADV_LEAD_DEF = 4;
    localparam int CNT_W_DEF    = 8;
    localparam int NUM_SLOTS    = 4;

    function automatic slot_e slot_inc(input slot_e s);
        return slot_e'(s + 2'd1);
    endfunction

endpackage

// File: rtl/fm_slot_timer.sv
// Slot counter and slot index for the frame-memory sequencer.
// Also produces the registered look-ahead pulse ADV_LEAD clocks before each slot end.
module fm_slot_timer
    import fm_seq_pkg::*;
#(
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int ADV_LEAD = ADV_LEAD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output slot_e slot_idx,
    output slot_e slot_nxt,
    output logic  wrap,
    output logic  stp_adv
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ADV  = CNT_W'(SLOT_LEN - 1 - ADV_LEAD);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             stp_nxt;

    // Everything holds while disabled; the pulse is keyed to the count being entered.
    always_comb begin
        cnt_nxt  = cnt;
        slot_nxt = slot_idx;
        wrap     = 1'b0;
        stp_nxt  = 1'b0;
        if (en) begin
            if (cnt == CNT_LAST) begin
                wrap     = 1'b1;
                cnt_nxt  = '0;
                slot_nxt = slot_inc(slot_idx);
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
            stp_nxt = (cnt_nxt == CNT_ADV);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            slot_idx <= SLOT_IVWR;
            stp_adv  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            slot_idx <= slot_nxt;
            stp_adv  <= stp_nxt;
        end
    end

endmodule

// File: rtl/fm_cycle_seq.sv
// Frame-memory cycle sequencer: slot decode, VSYNC capture and bank-select toggling.
// Banks flip only at the slot-3 to slot-0 wrap so readers always see a fully written bank.
module fm_cycle_seq
    import fm_seq_pkg::*;
#(
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int ADV_LEAD = ADV_LEAD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       VSYNC,
    input  logic       FREEZE,
    input  logic       SEQ_EN,
    output logic       FM_IV_WR_CYCLE,
    output logic       FM_OV_RD_CYCLE,
    output logic       FM_CYCLE_STP_ADV,
    output logic       FRAME_ALT,
    output logic       FRAME_ALT_FRZ,
    output logic [1:0] SLOT_IDX
);

    slot_e slot_idx;
    slot_e slot_nxt;
    logic  wrap;
    logic  vsync_q;
    logic  pend;
    logic  vs_edge;
    logic  toggle;

    fm_slot_timer #(
        .SLOT_LEN (SLOT_LEN),
        .ADV_LEAD (ADV_LEAD),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .en       (SEQ_EN),
        .slot_idx (slot_idx),
        .slot_nxt (slot_nxt),
        .wrap     (wrap),
        .stp_adv  (FM_CYCLE_STP_ADV)
    );

    assign SLOT_IDX = slot_idx;
    assign vs_edge  = VSYNC & ~vsync_q;
    assign toggle   = wrap && (slot_idx == SLOT_PROC_B) && pend;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vsync_q        <= 1'b0;
            pend           <= 1'b0;
            FM_IV_WR_CYCLE <= 1'b0;
            FM_OV_RD_CYCLE <= 1'b0;
            FRAME_ALT      <= 1'b0;
            FRAME_ALT_FRZ  <= 1'b0;
        end else begin
            vsync_q        <= VSYNC;
            // Decoded from the slot being entered so it lines up with SLOT_IDX.
            FM_IV_WR_CYCLE <= SEQ_EN && (slot_nxt == SLOT_IVWR);
            FM_OV_RD_CYCLE <= SEQ_EN && (slot_nxt == SLOT_OVRD);
            if (vs_edge) begin
                pend <= 1'b1;
            end else if (toggle) begin
                pend <= 1'b0;
            end
            if (toggle) begin
                FRAME_ALT <= ~FRAME_ALT;
                if (!FREEZE) begin
                    FRAME_ALT_FRZ <= ~FRAME_ALT;
                end
            end
        end
    end

endmodule

// File: tb/tb_fm_cycle_seq.sv
// Self-checking bench for fm_cycle_seq: tick-count reference model plus literal timing pins.
// "cyc N" below means the state right after the N-th clock edge following reset release.
module tb_fm_cycle_seq;
    import fm_seq_pkg::*;

    localparam int SLOT_LEN = 64;
    localparam int ADV_LEAD = 4;
    localparam int CNT_W    = 8;
    localparam int ROT_LEN  = SLOT_LEN * NUM_SLOTS;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       VSYNC = 1'b0;
    logic       FREEZE = 1'b0;
    logic       SEQ_EN = 1'b0;
    logic       FM_IV_WR_CYCLE;
    logic       FM_OV_RD_CYCLE;
    logic       FM_CYCLE_STP_ADV;
    logic       FRAME_ALT;
    logic       FRAME_ALT_FRZ;
    logic [1:0] SLOT_IDX;

    int tests = 0;
    int fails = 0;

    fm_cycle_seq #(
        .SLOT_LEN (SLOT_LEN),
        .ADV_LEAD (ADV_LEAD),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK              (clk),
        .RST              (RST),
        .VSYNC            (VSYNC),
        .FREEZE           (FREEZE),
        .SEQ_EN           (SEQ_EN),
        .FM_IV_WR_CYCLE   (FM_IV_WR_CYCLE),
        .FM_OV_RD_CYCLE   (FM_OV_RD_CYCLE),
        .FM_CYCLE_STP_ADV (FM_CYCLE_STP_ADV),
        .FRAME_ALT        (FRAME_ALT),
        .FRAME_ALT_FRZ    (FRAME_ALT_FRZ),
        .SLOT_IDX         (SLOT_IDX)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // ticks = enabled clocks since reset; slot and position follow from plain division.
    logic [6:0] exp_q[$];
    int   cyc = 0;
    int   ticks = 0;
    logic m_vs_q = 1'b0, m_pend = 1'b0, m_alt = 1'b0, m_frz = 1'b0;
    logic m_iv = 1'b0, m_ov = 1'b0, m_adv = 1'b0;
    int   m_slot = 0;

    always @(posedge clk) begin
        logic vs_edge;
        logic rot_end;
        if (RST) begin
            cyc = 0; ticks = 0;
            m_vs_q = 1'b0; m_pend = 1'b0; m_alt = 1'b0; m_frz = 1'b0;
            m_iv = 1'b0; m_ov = 1'b0; m_adv = 1'b0; m_slot = 0;
        end else begin
            cyc++;
            vs_edge = VSYNC && !m_vs_q;
            m_vs_q  = VSYNC;
            rot_end = 1'b0;
            if (SEQ_EN) begin
                ticks++;
                rot_end = (ticks % ROT_LEN == 0);
            end
            if (rot_end && m_pend) begin
                m_alt  = !m_alt;
                if (!FREEZE) m_frz = m_alt;
                m_pend = 1'b0;
            end
            if (vs_edge) m_pend = 1'b1;
            m_slot = (ticks / SLOT_LEN) % NUM_SLOTS;
            m_iv   = SEQ_EN && (m_slot == 0);
            m_ov   = SEQ_EN && (m_slot == 2);
            m_adv  = SEQ_EN && (ticks % SLOT_LEN == SLOT_LEN - 1 - ADV_LEAD);
        end
        exp_q.push_back({2'(m_slot), m_frz, m_alt, m_adv, m_ov, m_iv});
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [6:0] exp_v;
        logic [6:0] got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {SLOT_IDX, FRAME_ALT_FRZ, FRAME_ALT, FM_CYCLE_STP_ADV, FM_OV_RD_CYCLE, FM_IV_WR_CYCLE};
            tests++;
            if (got_v !== exp_v) begin
                fails++;
                $display("FAIL model_cmp t=%0t cyc=%0d got slot/frz/alt/adv/ov/iv=%b required=%b",
                         $time, cyc, got_v, exp_v);
            end
        end
    end

    // ---------------- event counters on DUT outputs ----------------
    int   adv_cnt = 0;
    int   tog_cnt = 0;
    logic alt_prev = 1'b0;

    always @(posedge clk) begin
        #2;
        if (FM_CYCLE_STP_ADV) adv_cnt++;
        if (FRAME_ALT !== alt_prev) tog_cnt++;
        alt_prev = FRAME_ALT;
    end

    // ---------------- driver tasks ----------------
    task automatic check_lit(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < n) begin
            tests++;
            fails++;
            $display("FAIL wait_cyc_timeout target=%0d reached=%0d", n, cyc);
        end
    endtask

    task automatic do_reset(input logic en, input logic frz);
        RST    = 1'b1;
        VSYNC  = 1'b0;
        SEQ_EN = en;
        FREEZE = frz;
        repeat (2) @(negedge clk);
        RST     = 1'b0;
        adv_cnt = 0;
        tog_cnt = 0;
    endtask

    task automatic pulse_vsync(input int n);
        wait_cyc(n - 1);
        VSYNC = 1'b1;
        wait_cyc(n);
        VSYNC = 1'b0;
    endtask

    function automatic int outs();
        return {FRAME_ALT_FRZ, FRAME_ALT, FM_CYCLE_STP_ADV, FM_OV_RD_CYCLE, FM_IV_WR_CYCLE, SLOT_IDX};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        // Reset state.
        do_reset(1'b1, 1'b0);
        RST = 1'b1;
        @(negedge clk);
        check_lit("reset_outputs", outs(), 0);
        RST = 1'b0;
        adv_cnt = 0;
        tog_cnt = 0;

        // Free-running slot pattern, absorbed second VSYNC, VSYNC on the toggle clock.
        wait_cyc(1);   check_lit("iv_first", FM_IV_WR_CYCLE, 1);
        wait_cyc(59);  check_lit("adv_slot0", FM_CYCLE_STP_ADV, 1);
        wait_cyc(63);  check_lit("iv_last", FM_IV_WR_CYCLE, 1);
        wait_cyc(64);  check_lit("slot1_idx", SLOT_IDX, 1);
                       check_lit("iv_off", FM_IV_WR_CYCLE, 0);
        pulse_vsync(100);
        wait_cyc(128); check_lit("ov_first", FM_OV_RD_CYCLE, 1);
        pulse_vsync(150);
        wait_cyc(191); check_lit("ov_last", FM_OV_RD_CYCLE, 1);
        wait_cyc(192); check_lit("slot3_ov_off", {SLOT_IDX, FM_OV_RD_CYCLE}, 3'b110);
        wait_cyc(255); check_lit("alt_before_wrap", {FRAME_ALT, FRAME_ALT_FRZ}, 0);
        VSYNC = 1'b1;
        wait_cyc(256); VSYNC = 1'b0;
        check_lit("alt_at_wrap", {FRAME_ALT, FRAME_ALT_FRZ}, 3);
        check_lit("adv_per_rotation", adv_cnt, 4);
        wait_cyc(511); check_lit("single_toggle", tog_cnt, 1);
        wait_cyc(512); check_lit("second_toggle", {FRAME_ALT, FRAME_ALT_FRZ}, 0);

        // Freeze across two toggles, mid-rotation release does not resync, then resync.
        do_reset(1'b1, 1'b1);
        pulse_vsync(100);
        wait_cyc(256); check_lit("frz_hold_1", {FRAME_ALT, FRAME_ALT_FRZ}, 2);
        wait_cyc(300); FREEZE = 1'b0;
        wait_cyc(350); check_lit("frz_no_midrot", {FRAME_ALT, FRAME_ALT_FRZ}, 2);
        wait_cyc(400); FREEZE = 1'b1;
        pulse_vsync(450);
        wait_cyc(512); check_lit("frz_hold_2", {FRAME_ALT, FRAME_ALT_FRZ}, 0);
                       check_lit("frz_toggles", tog_cnt, 2);
        wait_cyc(520); FREEZE = 1'b0;
        pulse_vsync(600);
        wait_cyc(767); check_lit("frz_pre_resync", {FRAME_ALT, FRAME_ALT_FRZ}, 0);
        wait_cyc(768); check_lit("frz_resync", {FRAME_ALT, FRAME_ALT_FRZ}, 3);

        // Pause for 30 clocks in the middle of slot 2.
        do_reset(1'b1, 1'b0);
        wait_cyc(150); SEQ_EN = 1'b0;
        wait_cyc(151); check_lit("pause_outputs", {SLOT_IDX, FM_OV_RD_CYCLE, FM_IV_WR_CYCLE}, 4'b1000);
        wait_cyc(180); check_lit("pause_held", {SLOT_IDX, FM_OV_RD_CYCLE, FM_CYCLE_STP_ADV}, 4'b1000);
        SEQ_EN = 1'b1;
        wait_cyc(181); check_lit("resume_ov", FM_OV_RD_CYCLE, 1);
        wait_cyc(217); check_lit("resume_adv", FM_CYCLE_STP_ADV, 1);
        wait_cyc(221); check_lit("resume_slot2_end", SLOT_IDX, 2);
        wait_cyc(222); check_lit("resume_slot3", SLOT_IDX, 3);

        // Reset mid-slot with a pending toggle discards it.
        do_reset(1'b1, 1'b0);
        pulse_vsync(100);
        wait_cyc(168);
        RST = 1'b1;
        @(negedge clk);
        check_lit("midslot_reset", outs(), 0);
        RST = 1'b0;
        tog_cnt = 0;
        wait_cyc(256); check_lit("pend_lost", FRAME_ALT, 0);
        wait_cyc(300); check_lit("pend_lost_cnt", tog_cnt, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            RST    = ($urandom_range(0, 799) == 0);
            SEQ_EN = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) VSYNC = ~VSYNC;
            if ($urandom_range(0, 199) == 0) FREEZE = ~FREEZE;
        end
        @(negedge clk);
        RST = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
